// File: rtl/btc_miner_pkg.sv
// Shared scheduler types and defaults: FSM state encoding, chunk/watchdog defaults, result width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btc_miner_pkg;

    localparam int CHUNK_LOG2_DEF = 20;
    localparam int RES_W          = 32;

    // Watchdog default scales with the job size: four job lengths of silence.
    function automatic int wdog_cycles_def(input int chunk_log2);
        return 1 << (chunk_log2 + 2);
    endfunction

    localparam int WDOG_CYCLES_DEF = wdog_cycles_def(CHUNK_LOG2_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } sched_state_t;

endpackage

// File: rtl/btc_job_scheduler_if.sv
// Core job handshake and result-FIFO read port between the scheduler and its neighbours.
// Latency: n/a (wires only).
// Backpressure: results are held in the FIFO until res_pop; the core side has none.
interface btc_job_scheduler_if
    import btc_miner_pkg::*;
();
    logic              core_start;
    logic [31:0]       core_nonce_in;
    logic              core_use_nonce_in;
    logic              core_done;
    logic              core_nonce_found;
    logic [31:0]       core_nonce_out;
    logic              res_valid;
    logic [RES_W-1:0]  res_nonce;
    logic              res_pop;

    modport master (
        output core_start, core_nonce_in, core_use_nonce_in,
        input  core_done, core_nonce_found, core_nonce_out,
        output res_valid, res_nonce,
        input  res_pop
    );

    modport slave (
        input  core_start, core_nonce_in, core_use_nonce_in,
        output core_done, core_nonce_found, core_nonce_out,
        input  res_valid, res_nonce,
        output res_pop
    );
endinterface

// File: rtl/btc_result_fifo.sv
// Found-nonce FIFO, first-word-fall-through; head is zero while empty.
// Latency: push visible at head one cycle later; pop takes effect on the clock edge.
// Backpressure: push while full is accepted only if a pop happens the same cycle, else dropped.
module btc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

    // Storage array: written only on accepted pushes, no reset needed since head is gated.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/btc_job_scheduler.sv
// Splits a nonce range into 2^CHUNK_LOG2 jobs for one hashing core and queues found nonces.
// Latency: 3 cycles overhead per job plus core time; BTC_SCHED_WATCHDOG_EN adds a WAIT watchdog.
// Backpressure: none toward the core; results beyond FIFO_DEPTH are dropped and flag overflow.
module btc_job_scheduler
    import btc_miner_pkg::*;
#(
    parameter int CHUNK_LOG2    = CHUNK_LOG2_DEF,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_ON_FOUND = 1
`ifdef BTC_SCHED_WATCHDOG_EN
    , parameter int WDOG_CYCLES = wdog_cycles_def(CHUNK_LOG2)
`endif
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        run,
    input  logic [31:0]                 range_lo,
    input  logic [31:0]                 range_hi,
    btc_job_scheduler_if.master         bus,
    output logic                        busy,
    output logic                        sweep_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] res_count,
    output logic                        timeout
);
    sched_state_t state_q, state_d;
    logic [1:0]   rst_sync;
    logic         rst_n;
    logic [31:0]  cur_q;
    logic         run_q, found_q, sweep_done_q, overflow_q;
    logic [32:0]  next_sum;
    logic         core_start, push_req, load_cur, step_cur, set_done;
    logic         fifo_full, fifo_drop, pop_ok, wdog_expire, retried_q;

    // Reset asserts immediately, releases two clocks after arst_n rises.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign next_sum = {1'b0, cur_q} + (33'd1 << CHUNK_LOG2);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-state strobes; dropping run abandons the sweep silently.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        push_req   = 1'b0;
        load_cur   = 1'b0;
        step_cur   = 1'b0;
        set_done   = 1'b0;
        if (state_q != S_IDLE && !run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run && !run_q) begin
                        load_cur = 1'b1;
                        state_d  = (range_lo > range_hi) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start = 1'b1;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.core_done) begin
                        push_req = bus.core_nonce_found;
                        state_d  = S_ADVANCE;
                    end else if (wdog_expire) begin
                        state_d = retried_q ? S_FINISH : S_ISSUE;
                    end
                end
                S_ADVANCE: begin
                    if (next_sum[32] || (next_sum[31:0] > range_hi) ||
                        ((STOP_ON_FOUND != 0) && found_q)) begin
                        state_d = S_FINISH;
                    end else begin
                        step_cur = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
                S_FINISH: begin
                    set_done = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pop_ok    = bus.res_pop && bus.res_valid;
    assign fifo_drop = push_req && fifo_full && !pop_ok;

    // Sweep datapath: job cursor, run edge detect, sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q        <= '0;
            run_q        <= 1'b0;
            found_q      <= 1'b0;
            sweep_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            run_q <= run;
            if (load_cur) begin
                cur_q        <= range_lo;
                found_q      <= 1'b0;
                sweep_done_q <= 1'b0;
                overflow_q   <= 1'b0;
            end else if (step_cur) begin
                cur_q <= next_sum[31:0];
            end
            if (push_req)  found_q      <= 1'b1;
            if (set_done)  sweep_done_q <= 1'b1;
            if (fifo_drop) overflow_q   <= 1'b1;
        end
    end

`ifdef BTC_SCHED_WATCHDOG_EN
    localparam int WW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    logic [WW-1:0] wdog_cnt_q;
    logic          timeout_q;

    assign wdog_expire = (state_q == S_WAIT) && (wdog_cnt_q == WW'(WDOG_CYCLES - 1));
    assign timeout     = timeout_q;

    // Watchdog counts consecutive WAIT cycles; one retry per job before giving up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            retried_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wdog_cnt_q <= (state_q == S_WAIT) ? wdog_cnt_q + 1'b1 : '0;
            if (load_cur || step_cur) retried_q <= 1'b0;
            else if (wdog_expire && !bus.core_done && run) retried_q <= 1'b1;
            if (load_cur) timeout_q <= 1'b0;
            else if (wdog_expire && !bus.core_done && run) timeout_q <= 1'b1;
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign retried_q   = 1'b0;
    assign timeout     = 1'b0;
`endif

    btc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (bus.core_nonce_out),
        .pop      (bus.res_pop),
        .head_dat (bus.res_nonce),
        .full     (fifo_full),
        .count    (res_count)
    );

    assign busy                  = (state_q != S_IDLE);
    assign sweep_done            = sweep_done_q;
    assign overflow              = overflow_q;
    assign bus.core_start        = core_start;
    assign bus.core_nonce_in     = cur_q;
    assign bus.core_use_nonce_in = busy;
    assign bus.res_valid         = (res_count != '0);
endmodule

// File: tb/tb_btc_job_scheduler.sv
// Directed bench: two schedulers (stop-on-found and run-through) share one scripted core.
// Latency: n/a.
// Backpressure: n/a.
module tb_btc_job_scheduler;
    import btc_miner_pkg::*;

    localparam int CL = 4;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   range_lo = '0;
    logic [31:0]   range_hi = '0;
    logic          core_done = 1'b0;
    logic          core_found = 1'b0;
    logic [31:0]   core_nout = '0;
    logic          res_pop = 1'b0;
    logic          busy_s, done_s, ovf_s, to_s;
    logic          busy_a, done_a, ovf_a, to_a;
    logic [CW-1:0] cnt_s, cnt_a;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    btc_job_scheduler_if bus_s();
    btc_job_scheduler_if bus_a();

    assign bus_s.core_done        = core_done;
    assign bus_s.core_nonce_found = core_found;
    assign bus_s.core_nonce_out   = core_nout;
    assign bus_s.res_pop          = res_pop;
    assign bus_a.core_done        = core_done;
    assign bus_a.core_nonce_found = core_found;
    assign bus_a.core_nonce_out   = core_nout;
    assign bus_a.res_pop          = res_pop;

    btc_job_scheduler #(
        .CHUNK_LOG2(CL), .FIFO_DEPTH(FD), .STOP_ON_FOUND(1)
`ifdef BTC_SCHED_WATCHDOG_EN
        , .WDOG_CYCLES(32)
`endif
    ) u_stop (
        .clk(clk), .arst_n(arst_n), .run(run), .range_lo(range_lo), .range_hi(range_hi),
        .bus(bus_s), .busy(busy_s), .sweep_done(done_s), .overflow(ovf_s),
        .res_count(cnt_s), .timeout(to_s)
    );

    btc_job_scheduler #(
        .CHUNK_LOG2(CL), .FIFO_DEPTH(FD), .STOP_ON_FOUND(0)
`ifdef BTC_SCHED_WATCHDOG_EN
        , .WDOG_CYCLES(32)
`endif
    ) u_all (
        .clk(clk), .arst_n(arst_n), .run(run), .range_lo(range_lo), .range_hi(range_hi),
        .bus(bus_a), .busy(busy_a), .sweep_done(done_a), .overflow(ovf_a),
        .res_count(cnt_a), .timeout(to_a)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          find_job;
        logic [31:0] find_nonce;
        int          starts;
        logic [31:0] first;
        logic [31:0] last;
        int          count;
        logic [31:0] head;
    } sweep_vec_t;

    sweep_vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a core_start from the selected scheduler; return its nonce.
    task automatic wait_start(input bit on_all, output logic [31:0] nonce);
        bit ok = 1'b0;
        nonce = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (on_all ? bus_a.core_start : bus_s.core_start) begin
                ok    = 1'b1;
                nonce = on_all ? bus_a.core_nonce_in : bus_s.core_nonce_in;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_start: no core_start within 100 cycles");
        end
    endtask

    // Scripted core: answer the next job after 3 cycles, optionally popping in the same cycle.
    task automatic core_job(input bit on_all, input bit found, input logic [31:0] nout,
                            input bit pop, output logic [31:0] nonce_in);
        wait_start(on_all, nonce_in);
        repeat (2) @(negedge clk);
        core_done = 1'b1; core_found = found; core_nout = nout; res_pop = pop;
        @(negedge clk);
        core_done = 1'b0; core_found = 1'b0; res_pop = 1'b0;
    endtask

    task automatic start_sweep(input logic [31:0] lo, input logic [31:0] hi);
        @(negedge clk);
        run = 1'b0; range_lo = lo; range_hi = hi;
        @(negedge clk);
        run = 1'b1;
    endtask

    // Full sweep on the stop-on-found instance, counting jobs until sweep_done.
    task automatic run_sweep(input int idx);
        int          starts = 0;
        logic [31:0] first = '0;
        logic [31:0] last = '0;
        bit          fin = 1'b0;
        start_sweep(vecs[idx].lo, vecs[idx].hi);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            if (bus_s.core_start) begin
                starts++;
                if (starts == 1) first = bus_s.core_nonce_in;
                last = bus_s.core_nonce_in;
                repeat (3) @(negedge clk);
                core_done  = 1'b1;
                core_found = (starts == vecs[idx].find_job);
                core_nout  = vecs[idx].find_nonce;
                @(negedge clk);
                core_done = 1'b0; core_found = 1'b0;
            end
            if (done_s) fin = 1'b1;
        end
        chk($sformatf("v%0d starts", idx), 32'(starts), 32'(vecs[idx].starts));
        chk($sformatf("v%0d first", idx), first, vecs[idx].first);
        chk($sformatf("v%0d last", idx), last, vecs[idx].last);
        chk($sformatf("v%0d sweep_done", idx), 32'(done_s), 32'd1);
        chk($sformatf("v%0d busy", idx), 32'(busy_s), 32'd0);
        chk($sformatf("v%0d res_count", idx), 32'(cnt_s), 32'(vecs[idx].count));
        chk($sformatf("v%0d res_nonce", idx), bus_s.res_nonce, vecs[idx].head);
        chk($sformatf("v%0d res_valid", idx), 32'(bus_s.res_valid), 32'(vecs[idx].count != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] n;
        logic [31:0] drain[4];
        int          gap, extra;
        bit          seen;

        vecs[0] = '{32'h0,        32'h3F,       0, 32'h0,    4, 32'h0,        32'h30,       0, 32'h0};
        vecs[1] = '{32'h5,        32'h25,       0, 32'h0,    3, 32'h5,        32'h25,       0, 32'h0};
        vecs[2] = '{32'hFFFFFFF0, 32'hFFFFFFFF, 0, 32'h0,    1, 32'hFFFFFFF0, 32'hFFFFFFF0, 0, 32'h0};
        vecs[3] = '{32'h40,       32'h3F,       0, 32'h0,    0, 32'h0,        32'h0,        0, 32'h0};
        vecs[4] = '{32'h0,        32'h3F,       2, 32'h1234, 2, 32'h0,        32'h10,       1, 32'h1234};

        // Reset state
        #1;
        chk("rst core_start", 32'(bus_s.core_start), 0);
        chk("rst core_nonce_in", bus_s.core_nonce_in, 0);
        chk("rst use_nonce", 32'(bus_s.core_use_nonce_in), 0);
        chk("rst res_valid", 32'(bus_s.res_valid), 0);
        chk("rst busy", 32'(busy_s), 0);
        chk("rst res_count", 32'(cnt_s), 0);
        chk("rst timeout", 32'(to_s), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) run_sweep(i);

        // Abort in WAIT; the late core_done must be ignored
        start_sweep(32'h0, 32'h3F);
        wait_start(1'b0, n);
        @(negedge clk);
        chk("abort in_wait busy", 32'(busy_s), 1);
        run = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy_s), 0);
        core_done = 1'b1; core_found = 1'b1; core_nout = 32'hDEAD;
        @(negedge clk);
        core_done = 1'b0; core_found = 1'b0;
        chk("abort res_count", 32'(cnt_s), 1);
        chk("abort res_nonce", bus_s.res_nonce, 32'h1234);
        chk("abort sweep_done", 32'(done_s), 0);
        chk("abort core_start", 32'(bus_s.core_start), 0);

        // Asynchronous reset mid-sweep clears outputs without a clock edge
        start_sweep(32'h100, 32'h1FF);
        wait_start(1'b0, n);
        chk("mid nonce", n, 32'h100);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("arst core_start", 32'(bus_s.core_start), 0);
        chk("arst core_nonce_in", bus_s.core_nonce_in, 0);
        chk("arst use_nonce", 32'(bus_s.core_use_nonce_in), 0);
        chk("arst res_valid", 32'(bus_s.res_valid), 0);
        chk("arst res_nonce", bus_s.res_nonce, 0);
        chk("arst busy", 32'(busy_s), 0);
        chk("arst sweep_done", 32'(done_s), 0);
        chk("arst overflow", 32'(ovf_s), 0);
        chk("arst res_count", 32'(cnt_s), 0);
        chk("arst timeout", 32'(to_s), 0);
        @(negedge clk);
        run = 1'b0; arst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Overflow on the run-through instance: 5 finds into a 4-deep FIFO
        start_sweep(32'h0, 32'hFF);
        for (int k = 1; k <= 5; k++) begin
            core_job(1'b1, 1'b1, 32'hA000 + 32'(k), 1'b0, n);
            chk($sformatf("ovf job%0d nonce", k), n, 32'((k - 1) * 16));
            if (k == 4) begin
                chk("ovf full count", 32'(cnt_a), 4);
                chk("ovf not yet", 32'(ovf_a), 0);
            end
        end
        chk("ovf count", 32'(cnt_a), 4);
        chk("ovf flag", 32'(ovf_a), 1);
        chk("ovf head", bus_a.res_nonce, 32'hA001);
        chk("ovf valid", 32'(bus_a.res_valid), 1);
        core_job(1'b1, 1'b1, 32'hA006, 1'b1, n);
        chk("pushpop count", 32'(cnt_a), 4);
        chk("pushpop head", bus_a.res_nonce, 32'hA002);
        drain = '{32'hA002, 32'hA003, 32'hA004, 32'hA006};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), bus_a.res_nonce, drain[k]);
            res_pop = 1'b1;
            @(negedge clk);
            res_pop = 1'b0;
        end
        chk("drain count", 32'(cnt_a), 0);
        chk("drain valid", 32'(bus_a.res_valid), 0);
        run = 1'b0;
        repeat (2) @(negedge clk);

`ifdef BTC_SCHED_WATCHDOG_EN
        // Silent core: retry after 32 WAIT cycles, give up after the second expiry
        start_sweep(32'h0, 32'h3F);
        wait_start(1'b0, n);
        gap = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (bus_s.core_start) seen = 1'b1;
        end
        chk("wd retry gap", 32'(gap), 33);
        chk("wd retry nonce", bus_s.core_nonce_in, 32'h0);
        chk("wd timeout", 32'(to_s), 1);
        gap = 0; extra = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (bus_s.core_start) extra++;
            if (done_s) seen = 1'b1;
        end
        chk("wd finish gap", 32'(gap), 34);
        chk("wd extra starts", 32'(extra), 0);
        chk("wd sweep_done", 32'(done_s), 1);
        chk("wd busy", 32'(busy_s), 0);
`else
        // Without the watchdog a silent core leaves WAIT pending indefinitely
        start_sweep(32'h0, 32'h3F);
        wait_start(1'b0, n);
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus_s.core_start) extra++;
        end
        chk("nowd extra starts", 32'(extra), 0);
        chk("nowd busy", 32'(busy_s), 1);
        chk("nowd timeout", 32'(to_s), 0);
`endif
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btc_job_scheduler.md
BTC_JOB_SCHEDULER -- requirements
Module: btc_job_scheduler

Interface
REQ-001 SHALL have parameter CHUNK_LOG2, default 20, meaning each core job sweeps 2^CHUNK_LOG2 nonces.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), meaning result FIFO entries.
REQ-003 SHALL have parameter STOP_ON_FOUND, default 1, meaning halt the range after the first found nonce.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (sole clock); arst_n input 1 (async, active-low).
REQ-005 SHALL have ports: run input 1 (level; sweep enable); range_lo input 32 (first nonce); range_hi input 32 (last nonce, inclusive).
REQ-006 SHALL have ports: core_start output 1 (one-cycle job pulse); core_nonce_in output 32 (job base nonce); core_use_nonce_in output 1 (constant 1 while busy).
REQ-007 SHALL have ports: core_done input 1 (one-cycle job-complete pulse); core_nonce_found input 1 (valid with core_done); core_nonce_out input 32 (valid with core_done).
REQ-008 SHALL have ports: res_valid output 1; res_nonce output 32; res_pop input 1 (FIFO read, honoured only when res_valid).
REQ-009 SHALL have ports: busy output 1; sweep_done output 1 (sticky); overflow output 1 (sticky); res_count output $clog2(FIFO_DEPTH)+1; timeout output 1 (sticky, watchdog builds only).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, ADVANCE, FINISH.
REQ-011 IDLE: on run rising edge, SHALL load cur=range_lo, clear sweep_done/overflow/timeout, and go to ISSUE; if range_lo>range_hi, SHALL go directly to FINISH.
REQ-012 ISSUE: SHALL assert core_start for exactly one cycle with core_nonce_in=cur, then go to WAIT.
REQ-013 WAIT: SHALL hold until core_done; on core_done with core_nonce_found, SHALL push core_nonce_out into the FIFO in that cycle.
REQ-014 ADVANCE: next=cur+2^CHUNK_LOG2, computed 33-bit; if carry set, or next>range_hi, or (STOP_ON_FOUND and a nonce was found this sweep), SHALL go to FINISH; otherwise SHALL set cur=next and go to ISSUE.
REQ-015 FINISH: SHALL set sweep_done and go to IDLE; a new sweep requires run low then high.
REQ-016 Sweep latency SHALL be 3 cycles of overhead per job (ISSUE, ADVANCE, WAIT exit) plus core time.
REQ-017 run deasserted in any non-IDLE state SHALL return to IDLE next cycle, with no core_start issued and sweep_done left clear; a core_done arriving later SHALL be ignored.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 FIFO: first-word-fall-through; res_nonce=head; res_valid=(res_count!=0).
REQ-020 A push while full with no pop SHALL drop the push and set overflow.
REQ-021 A simultaneous push and pop while full SHALL accept both, leaving res_count unchanged.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 FIFO contents SHALL persist across sweeps; they are cleared only by reset.

Reset
REQ-024 On arst_n low, SHALL immediately enter IDLE, with cur=0, FIFO empty, and all outputs 0: core_start, core_nonce_in, core_use_nonce_in, res_valid, res_nonce, busy, sweep_done, overflow, res_count, timeout.
REQ-025 Reset release SHALL be synchronised to clk internally using a 2-flop release-only synchroniser.

Configuration
REQ-026 With BTC_SCHED_WATCHDOG_EN defined, SHALL add a parameter WDOG_CYCLES (default 2^(CHUNK_LOG2+2)); a WAIT lasting WDOG_CYCLES cycles SHALL set timeout and go to ISSUE with the same cur (retry once); a second timeout on that job SHALL go to FINISH.
REQ-027 Without BTC_SCHED_WATCHDOG_EN, SHALL omit the counter entirely; timeout SHALL be tied to 0 and WAIT SHALL wait indefinitely.

Structure
REQ-028 SHALL place the FSM state enum, the CHUNK and WDOG default constants, and the result-record width in shared package btc_miner_pkg.
REQ-029 SHALL implement the result FIFO as sub-module btc_result_fifo (parameter DEPTH, WIDTH=32; push/pop/full/count).

Verification
REQ-030 Bench SHALL cover basic sweep: CHUNK_LOG2=4, range 0x0..0x3F, no finds -> 4 core_start pulses with nonce_in 0x00, 0x10, 0x20, 0x30, then sweep_done=1 and res_count=0.
REQ-031 Bench SHALL cover find with stop: STOP_ON_FOUND=1, find reported on job 2 with nonce_out 0x1234 -> res_nonce=0x1234, res_valid=1, no 3rd start, sweep_done=1.
REQ-032 Bench SHALL cover wrap-around: range 0xFFFFFFF0..0xFFFFFFFF, CHUNK_LOG2=4 -> exactly 1 start at 0xFFFFFFF0, then FINISH (carry case).
REQ-033 Bench SHALL cover overflow: FIFO_DEPTH=4, STOP_ON_FOUND=0, 5 finds with no pops -> res_count=4, overflow=1, head=first nonce; push+pop on the same cycle while full -> res_count stays 4.
REQ-034 Bench SHALL cover abort: run dropped in WAIT, then core_done pulsed -> IDLE, busy=0, no FIFO push; arst_n asserted mid-sweep -> all outputs 0 immediately.
REQ-035 Bench SHALL cover watchdog: with BTC_SCHED_WATCHDOG_EN, WDOG_CYCLES=32, core silent -> retry start at the same nonce after 32 cycles, timeout=1, FINISH after the second expiry.
